// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, per-register pending-producer
// counters (scoreboard), a registered debug read port and a sticky error flag.
module regfile_mp #(
   parameter int DATA_W  = 32,
   parameter int NREG    = 32,
   parameter int NRD     = 4,
   parameter int NWR     = 2,
   parameter int CNT_W   = 2,
   localparam int AW     = $clog2(NREG)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD*AW-1:0]     raddr,
   output logic [NRD*DATA_W-1:0] rdata,
   output logic [NRD-1:0]        rbusy,
   input  logic [NWR-1:0]        wen,
   input  logic [NWR*AW-1:0]     waddr,
   input  logic [NWR*DATA_W-1:0] wdata,
   input  logic [NWR-1:0]        alloc_en,
   input  logic [NWR*AW-1:0]     alloc_addr,
   input  logic [AW-1:0]         dbg_addr,
   output logic [DATA_W-1:0]     dbg_data,
   output logic                  err
);

   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [CNT_W-1:0]  cnt_q  [NREG];
   logic [CNT_W-1:0]  cnt_d  [NREG];
   logic              err_q;
   logic              err_d;
   logic [DATA_W-1:0] dbg_q;

   logic [AW-1:0]     rd_a;
   logic signed [31:0] rd_hits;
   logic signed [31:0] rd_net;
   logic signed [31:0] cnt_net;

   // Read ports: later write ports override earlier ones, so the highest
   // index hit wins; rbusy discounts producers retiring this very cycle.
   always_comb begin
      rdata   = '0;
      rbusy   = '0;
      rd_a    = '0;
      rd_hits = '0;
      rd_net  = '0;
      for (int unsigned i = 0; i < NRD; i++) begin
         rd_a    = raddr[i*AW +: AW];
         rd_hits = '0;
         if (rd_a != '0) begin
            rdata[i*DATA_W +: DATA_W] = regs_q[rd_a];
            for (int unsigned j = 0; j < NWR; j++) begin
               if (wen[j] && (waddr[j*AW +: AW] == rd_a)) begin
                  rdata[i*DATA_W +: DATA_W] = wdata[j*DATA_W +: DATA_W];
                  rd_hits = rd_hits + 1;
               end
            end
            rd_net   = 32'(cnt_q[rd_a]) - rd_hits;
            rbusy[i] = (rd_net > 0);
         end
      end
   end

   always_comb begin
      regs_d = regs_q;
      for (int unsigned j = 0; j < NWR; j++) begin
         if (wen[j] && (waddr[j*AW +: AW] != '0)) begin
            regs_d[waddr[j*AW +: AW]] = wdata[j*DATA_W +: DATA_W];
         end
      end
   end

   // Net counter update per register; register 0 never tracks producers.
   always_comb begin
      cnt_d   = cnt_q;
      err_d   = err_q;
      cnt_net = '0;
      for (int unsigned r = 1; r < NREG; r++) begin
         cnt_net = 32'(cnt_q[r]);
         for (int unsigned j = 0; j < NWR; j++) begin
            if (alloc_en[j] && (alloc_addr[j*AW +: AW] == AW'(r))) begin
               cnt_net = cnt_net + 1;
            end
            if (wen[j] && (waddr[j*AW +: AW] == AW'(r))) begin
               cnt_net = cnt_net - 1;
            end
         end
         if (cnt_net > CNT_MAX) begin
            cnt_d[r] = '1;
            err_d    = 1'b1;
         end else if (cnt_net < 0) begin
            cnt_d[r] = '0;
            err_d    = 1'b1;
         end else begin
            cnt_d[r] = CNT_W'(cnt_net);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q <= '{default: '0};
         cnt_q  <= '{default: '0};
         err_q  <= 1'b0;
         dbg_q  <= '0;
      end else begin
         regs_q <= regs_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
         dbg_q  <= regs_q[dbg_addr];
      end
   end

   assign dbg_data = dbg_q;
   assign err      = err_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed scenarios plus random traffic,
// expectations from a behavioural model, checked by a negedge monitor.
module tb_regfile_mp;

   localparam int DW    = 32;
   localparam int NREG  = 32;
   localparam int NRD   = 4;
   localparam int NWR   = 2;
   localparam int CNT_W = 2;
   localparam int AW    = 5;
   localparam int CMAX  = 3;

   localparam int K_RDATA = 0;
   localparam int K_RBUSY = 1;
   localparam int K_ERR   = 2;
   localparam int K_DBG   = 3;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NRD*AW-1:0]   raddr = '0;
   logic [NRD*DW-1:0]   rdata;
   logic [NRD-1:0]      rbusy;
   logic [NWR-1:0]      wen = '0;
   logic [NWR*AW-1:0]   waddr = '0;
   logic [NWR*DW-1:0]   wdata = '0;
   logic [NWR-1:0]      alloc_en = '0;
   logic [NWR*AW-1:0]   alloc_addr = '0;
   logic [AW-1:0]       dbg_addr = '0;
   logic [DW-1:0]       dbg_data;
   logic                err;

   regfile_mp #(.DATA_W(DW), .NREG(NREG), .NRD(NRD), .NWR(NWR), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
      .wen(wen), .waddr(waddr), .wdata(wdata), .alloc_en(alloc_en),
      .alloc_addr(alloc_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      int          idx;
      logic [DW-1:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Behavioural model state
   logic [DW-1:0] m_mem [NREG];
   int            m_cnt [NREG];
   logic          m_err;
   logic [DW-1:0] m_dbg;

   function automatic void expect_v(int kind, int idx, logic [DW-1:0] v);
      exp_t e;
      e.kind = kind;
      e.idx  = idx;
      e.val  = v;
      sb.push_back(e);
   endfunction

   function automatic logic [DW-1:0] m_read(int i);
      int a = int'(raddr[i*AW +: AW]);
      logic [DW-1:0] v;
      if (a == 0) return '0;
      v = m_mem[a];
      for (int j = 0; j < NWR; j++)
         if (wen[j] && int'(waddr[j*AW +: AW]) == a) v = wdata[j*DW +: DW];
      return v;
   endfunction

   function automatic logic m_busy(int i);
      int a = int'(raddr[i*AW +: AW]);
      int pend;
      if (a == 0) return 1'b0;
      pend = m_cnt[a];
      for (int j = 0; j < NWR; j++)
         if (wen[j] && int'(waddr[j*AW +: AW]) == a) pend--;
      return pend > 0;
   endfunction

   function automatic void model_update();
      int d;
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            m_mem[r] = '0;
            m_cnt[r] = 0;
         end
         m_err = 1'b0;
         m_dbg = '0;
         return;
      end
      m_dbg = m_mem[dbg_addr];
      for (int r = 1; r < NREG; r++) begin
         d = 0;
         for (int j = 0; j < NWR; j++) begin
            if (alloc_en[j] && int'(alloc_addr[j*AW +: AW]) == r) d++;
            if (wen[j] && int'(waddr[j*AW +: AW]) == r) d--;
         end
         if (m_cnt[r] + d > CMAX) begin
            m_cnt[r] = CMAX;
            m_err    = 1'b1;
         end else if (m_cnt[r] + d < 0) begin
            m_cnt[r] = 0;
            m_err    = 1'b1;
         end else begin
            m_cnt[r] = m_cnt[r] + d;
         end
      end
      for (int j = 0; j < NWR; j++)
         if (wen[j] && waddr[j*AW +: AW] != '0) m_mem[waddr[j*AW +: AW]] = wdata[j*DW +: DW];
   endfunction

   task automatic idle();
      wen      = '0;
      alloc_en = '0;
   endtask

   task automatic set_w(int j, int a, logic [DW-1:0] d);
      wen[j]              = 1'b1;
      waddr[j*AW +: AW]   = AW'(a);
      wdata[j*DW +: DW]   = d;
   endtask

   task automatic set_a(int j, int a);
      alloc_en[j]            = 1'b1;
      alloc_addr[j*AW +: AW] = AW'(a);
   endtask

   task automatic set_r(int i, int a);
      raddr[i*AW +: AW] = AW'(a);
   endtask

   // Push this cycle's model expectations, then advance one clock.
   task automatic step();
      for (int i = 0; i < NRD; i++) begin
         expect_v(K_RDATA, i, m_read(i));
         if (!rst) expect_v(K_RBUSY, i, {31'b0, m_busy(i)});
      end
      expect_v(K_ERR, 0, {31'b0, m_err});
      expect_v(K_DBG, 0, m_dbg);
      @(posedge clk);
      model_update();
      #1;
   endtask

   function automatic logic [DW-1:0] actual(int kind, int idx);
      case (kind)
         K_RDATA: return rdata[idx*DW +: DW];
         K_RBUSY: return {31'b0, rbusy[idx]};
         K_ERR:   return {31'b0, err};
         default: return dbg_data;
      endcase
   endfunction

   function automatic string kname(int kind);
      case (kind)
         K_RDATA: return "rdata";
         K_RBUSY: return "rbusy";
         K_ERR:   return "err";
         default: return "dbg_data";
      endcase
   endfunction

   // Monitor: outputs are stable mid-cycle; drain everything queued for it.
   initial begin
      exp_t        e;
      logic [DW-1:0] act;
      forever begin
         @(negedge clk);
         while (sb.size() != 0) begin
            e   = sb.pop_front();
            act = actual(e.kind, e.idx);
            n_checks++;
            if (act === e.val) n_pass++;
            else $display("FAIL %s[%0d]: got %h expected %h at %0t",
                          kname(e.kind), e.idx, act, e.val, $time);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      @(posedge clk);
      model_update();
      #1;
      step();
      rst = 1'b0;

      // Two allocs then two writebacks on r7
      idle(); set_a(0, 7); step();
      idle(); set_a(0, 7); step();
      idle(); set_r(0, 7); expect_v(K_RBUSY, 0, 1); step();
      idle(); set_r(0, 7); set_w(0, 7, 32'h77); expect_v(K_RBUSY, 0, 1); step();
      idle(); set_r(0, 7); set_w(0, 7, 32'h78); expect_v(K_RBUSY, 0, 0); step();

      // Simultaneous alloc and writeback on r3
      idle(); set_a(0, 3); step();
      idle(); set_a(0, 3); set_w(1, 3, 32'h33); step();
      idle(); set_r(0, 3); expect_v(K_RBUSY, 0, 1); expect_v(K_ERR, 0, 0); step();
      idle(); set_w(0, 3, 32'h34); step();

      // Same-address writes: highest port wins in bypass and in storage
      idle(); set_a(0, 5); set_a(1, 5); step();
      idle(); set_w(0, 5, 32'hAAAA); set_w(1, 5, 32'hBBBB); set_r(0, 5);
      expect_v(K_RDATA, 0, 32'hBBBB); step();
      idle(); set_r(0, 5); dbg_addr = 5; expect_v(K_RDATA, 0, 32'hBBBB); step();
      idle(); expect_v(K_DBG, 0, 32'hBBBB); step();

      // Register 0 is hardwired
      idle(); set_w(0, 0, 32'hFFFF_FFFF); set_r(0, 0);
      expect_v(K_RDATA, 0, 0); expect_v(K_RBUSY, 0, 0); step();
      idle(); set_r(0, 0); expect_v(K_RDATA, 0, 0); expect_v(K_RBUSY, 0, 0); step();

      // Counter overflow on r9 is sticky
      for (int k = 0; k < 4; k++) begin
         idle(); set_a(0, 9); step();
      end
      idle(); set_r(0, 9); expect_v(K_ERR, 0, 1); expect_v(K_RBUSY, 0, 1); step();
      idle(); set_w(0, 9, 32'h99); step();
      idle(); set_r(0, 9); expect_v(K_ERR, 0, 1); expect_v(K_RBUSY, 0, 1); step();

      // Reset in the middle of activity
      idle(); set_w(0, 31, 32'h1234); step();
      idle(); set_a(0, 4); set_a(1, 4); dbg_addr = 31; step();
      idle(); set_r(0, 31); set_r(1, 4);
      expect_v(K_RDATA, 0, 32'h1234); expect_v(K_RBUSY, 1, 1); expect_v(K_ERR, 0, 1); step();
      idle(); rst = 1'b1; step();
      rst = 1'b0;
      idle(); set_r(0, 31); set_r(1, 4);
      expect_v(K_RDATA, 0, 0); expect_v(K_RBUSY, 1, 0);
      expect_v(K_ERR, 0, 0); expect_v(K_DBG, 0, 0); step();

      // Random traffic over a small address window to force collisions
      for (int c = 0; c < 400; c++) begin
         idle();
         rst = ($urandom_range(0, 59) == 0);
         for (int j = 0; j < NWR; j++) begin
            if ($urandom_range(0, 2) == 0) set_w(j, $urandom_range(0, 7), $urandom);
            if ($urandom_range(0, 1) == 0) set_a(j, $urandom_range(0, 7));
         end
         for (int i = 0; i < NRD; i++) set_r(i, $urandom_range(0, 7));
         dbg_addr = AW'($urandom_range(0, 7));
         step();
      end

      rst = 1'b0;
      idle();
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
